// File: rtl/alu_issue_pkg.sv
// Shared constants for the ALU issue controller: ALU op codes, MIPS fields, FSM states.
// Default datapath width comes from `D_WIDTH; `ALU_DIVZERO_CHK_EN is consumed by alu_issue.
`ifndef D_WIDTH
`define D_WIDTH 32
`endif

package alu_issue_pkg;

    localparam logic [2:0] AluAdd = 3'd0;
    localparam logic [2:0] AluSub = 3'd1;
    localparam logic [2:0] AluMul = 3'd2;
    localparam logic [2:0] AluDiv = 3'd3;
    localparam logic [2:0] AluSll = 3'd4;
    localparam logic [2:0] AluSrl = 3'd5;

    localparam logic [5:0] OpcSpecial = 6'h00;
    localparam logic [5:0] OpcAddi    = 6'h08;

    localparam logic [5:0] FnAdd  = 6'h20;
    localparam logic [5:0] FnSub  = 6'h22;
    localparam logic [5:0] FnMult = 6'h18;
    localparam logic [5:0] FnDiv  = 6'h1A;
    localparam logic [5:0] FnSll  = 6'h00;
    localparam logic [5:0] FnSrl  = 6'h02;

    typedef enum logic [1:0] {
        StIdle,
        StExec,
        StWait,
        StWb
    } state_e;

endpackage

// File: rtl/alu_issue_decode.sv
// Combinational decode of a MIPS instruction word into ALU op, operands, destination
// and legality flags.
module alu_issue_decode
    import alu_issue_pkg::*;
#(
    parameter int unsigned D_WIDTH = `D_WIDTH
) (
    input  logic [31:0]        instr,
    input  logic [D_WIDTH-1:0] rs_val,
    input  logic [D_WIDTH-1:0] rt_val,
    output logic [2:0]         op,
    output logic [D_WIDTH-1:0] operand1,
    output logic [D_WIDTH-1:0] operand2,
    output logic [4:0]         dest,
    output logic               muldiv,
    output logic               div_zero,
    output logic               illegal
);

    logic [5:0]         opcode;
    logic [5:0]         funct;
    logic [D_WIDTH-1:0] imm_sext;
    logic [D_WIDTH-1:0] shamt_zext;
    logic               unused_rs_field;

    assign opcode          = instr[31:26];
    assign funct           = instr[5:0];
    assign imm_sext        = {{(D_WIDTH-16){instr[15]}}, instr[15:0]};
    assign shamt_zext      = {{(D_WIDTH-5){1'b0}}, instr[10:6]};
    // The rs register number is resolved upstream; only its value arrives here.
    assign unused_rs_field = ^instr[25:21];

    always_comb begin
        op       = AluAdd;
        operand1 = rs_val;
        operand2 = rt_val;
        dest     = instr[15:11];
        muldiv   = 1'b0;
        illegal  = 1'b0;
        if (opcode == OpcSpecial) begin
            case (funct)
                FnAdd:  op = AluAdd;
                FnSub:  op = AluSub;
                FnMult: begin
                    op     = AluMul;
                    muldiv = 1'b1;
                end
                FnDiv: begin
                    op     = AluDiv;
                    muldiv = 1'b1;
                end
                FnSll: begin
                    op       = AluSll;
                    operand1 = rt_val;
                    operand2 = shamt_zext;
                end
                FnSrl: begin
                    op       = AluSrl;
                    operand1 = rt_val;
                    operand2 = shamt_zext;
                end
                default: illegal = 1'b1;
            endcase
        end else if (opcode == OpcAddi) begin
            op       = AluAdd;
            operand2 = imm_sext;
            dest     = instr[20:16];
        end else begin
            illegal = 1'b1;
        end
    end

    assign div_zero = (opcode == OpcSpecial) && (funct == FnDiv) && (rt_val == '0);

endmodule

// File: rtl/alu_issue.sv
// Execute-stage issue controller: decodes, drives the external ALU for the required
// cycles, captures the result and hands it to writeback. Option: `ALU_DIVZERO_CHK_EN.
module alu_issue
    import alu_issue_pkg::*;
#(
    parameter int unsigned D_WIDTH    = `D_WIDTH,
    parameter int unsigned MULDIV_LAT = 4
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [31:0]        instr,
    input  logic [D_WIDTH-1:0] rs_val,
    input  logic [D_WIDTH-1:0] rt_val,
    output logic [2:0]         alu_op_code,
    output logic [D_WIDTH-1:0] alu_operand1,
    output logic [D_WIDTH-1:0] alu_operand2,
    output logic               alu_enable,
    input  logic [D_WIDTH-1:0] alu_result,
    output logic               wb_valid,
    input  logic               wb_ready,
    output logic [4:0]         wb_addr,
    output logic [D_WIDTH-1:0] wb_data,
    output logic               illegal,
    output logic               divzero
);

    localparam int unsigned CntW = (MULDIV_LAT > 1) ? $clog2(MULDIV_LAT) : 1;

`ifdef ALU_DIVZERO_CHK_EN
    localparam bit DivZeroChk = 1'b1;
`else
    localparam bit DivZeroChk = 1'b0;
`endif

    logic [2:0]         dec_op;
    logic [D_WIDTH-1:0] dec_operand1;
    logic [D_WIDTH-1:0] dec_operand2;
    logic [4:0]         dec_dest;
    logic               dec_muldiv;
    logic               dec_div_zero;
    logic               dec_illegal;

    state_e             state_q, state_d;
    logic [2:0]         op_q, op_d;
    logic [D_WIDTH-1:0] opnd1_q, opnd1_d;
    logic [D_WIDTH-1:0] opnd2_q, opnd2_d;
    logic [4:0]         dest_q, dest_d;
    logic               muldiv_q, muldiv_d;
    logic [CntW-1:0]    cnt_q, cnt_d;
    logic [D_WIDTH-1:0] wb_data_q, wb_data_d;
    logic               illegal_q, illegal_d;
    logic               divzero_q, divzero_d;

    alu_issue_decode #(
        .D_WIDTH (D_WIDTH)
    ) u_decode (
        .instr    (instr),
        .rs_val   (rs_val),
        .rt_val   (rt_val),
        .op       (dec_op),
        .operand1 (dec_operand1),
        .operand2 (dec_operand2),
        .dest     (dec_dest),
        .muldiv   (dec_muldiv),
        .div_zero (dec_div_zero),
        .illegal  (dec_illegal)
    );

    always_comb begin
        state_d   = state_q;
        op_d      = op_q;
        opnd1_d   = opnd1_q;
        opnd2_d   = opnd2_q;
        dest_d    = dest_q;
        muldiv_d  = muldiv_q;
        cnt_d     = cnt_q;
        wb_data_d = wb_data_q;
        illegal_d = 1'b0;
        divzero_d = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (in_valid) begin
                    if (dec_illegal) begin
                        illegal_d = 1'b1;
                    end else if (dec_div_zero && DivZeroChk) begin
                        // Divide by zero bypasses the ALU entirely.
                        dest_d    = dec_dest;
                        wb_data_d = '1;
                        divzero_d = 1'b1;
                        state_d   = (dec_dest == 5'd0) ? StIdle : StWb;
                    end else begin
                        op_d     = dec_op;
                        opnd1_d  = dec_operand1;
                        opnd2_d  = dec_operand2;
                        dest_d   = dec_dest;
                        muldiv_d = dec_muldiv;
                        state_d  = StExec;
                    end
                end
            end
            StExec: begin
                if (muldiv_q && (MULDIV_LAT > 1)) begin
                    cnt_d   = CntW'(MULDIV_LAT - 1);
                    state_d = StWait;
                end else begin
                    wb_data_d = alu_result;
                    state_d   = (dest_q == 5'd0) ? StIdle : StWb;
                end
            end
            StWait: begin
                cnt_d = cnt_q - 1'b1;
                if (cnt_q == CntW'(1)) begin
                    wb_data_d = alu_result;
                    state_d   = (dest_q == 5'd0) ? StIdle : StWb;
                end
            end
            StWb: begin
                if (wb_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q   <= StIdle;
            op_q      <= '0;
            opnd1_q   <= '0;
            opnd2_q   <= '0;
            dest_q    <= '0;
            muldiv_q  <= 1'b0;
            cnt_q     <= '0;
            wb_data_q <= '0;
            illegal_q <= 1'b0;
            divzero_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            op_q      <= op_d;
            opnd1_q   <= opnd1_d;
            opnd2_q   <= opnd2_d;
            dest_q    <= dest_d;
            muldiv_q  <= muldiv_d;
            cnt_q     <= cnt_d;
            wb_data_q <= wb_data_d;
            illegal_q <= illegal_d;
            divzero_q <= divzero_d;
        end
    end

    assign in_ready     = (state_q == StIdle);
    assign alu_enable   = (state_q == StExec) || (state_q == StWait);
    assign wb_valid     = (state_q == StWb);
    assign alu_op_code  = op_q;
    assign alu_operand1 = opnd1_q;
    assign alu_operand2 = opnd2_q;
    assign wb_addr      = dest_q;
    assign wb_data      = wb_data_q;
    assign illegal      = illegal_q;
    assign divzero      = divzero_q;

endmodule

// File: tb/tb_alu_issue.sv
// Self-checking bench for alu_issue: behavioural ALU, spec-level reference model,
// directed table, randomized transactions and reset corner cases.
module tb_alu_issue;

    localparam int LAT = 4;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] instr;
    logic [31:0] rs_val;
    logic [31:0] rt_val;
    logic [2:0]  alu_op_code;
    logic [31:0] alu_operand1;
    logic [31:0] alu_operand2;
    logic        alu_enable;
    logic [31:0] alu_result;
    logic        wb_valid;
    logic        wb_ready;
    logic [4:0]  wb_addr;
    logic [31:0] wb_data;
    logic        illegal;
    logic        divzero;

    int n_checks = 0;
    int n_pass   = 0;
    int stab_err = 0;
    int en_run   = 0;

    always #5 clk = ~clk;

    alu_issue #(
        .D_WIDTH    (32),
        .MULDIV_LAT (LAT)
    ) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .instr        (instr),
        .rs_val       (rs_val),
        .rt_val       (rt_val),
        .alu_op_code  (alu_op_code),
        .alu_operand1 (alu_operand1),
        .alu_operand2 (alu_operand2),
        .alu_enable   (alu_enable),
        .alu_result   (alu_result),
        .wb_valid     (wb_valid),
        .wb_ready     (wb_ready),
        .wb_addr      (wb_addr),
        .wb_data      (wb_data),
        .illegal      (illegal),
        .divzero      (divzero)
    );

    // ALU stand-in: garbage unless enabled, and mult/div only valid after LAT enabled cycles.
    always_ff @(posedge clk) en_run <= alu_enable ? en_run + 1 : 0;

    always_comb begin
        alu_result = 32'hDEAD_BEEF;
        if (alu_enable) begin
            case (alu_op_code)
                3'd0: alu_result = alu_operand1 + alu_operand2;
                3'd1: alu_result = alu_operand1 - alu_operand2;
                3'd2: alu_result = (en_run + 1 >= LAT) ? alu_operand1 * alu_operand2
                                                        : 32'hBAD0_BAD0;
                3'd3: begin
                    if (en_run + 1 < LAT) alu_result = 32'hBAD0_BAD0;
                    else if (alu_operand2 == 0) alu_result = 32'hFFFF_FFFF;
                    else alu_result = alu_operand1 / alu_operand2;
                end
                3'd4: alu_result = alu_operand1 << alu_operand2[4:0];
                3'd5: alu_result = alu_operand1 >> alu_operand2[4:0];
                default: alu_result = 32'hDEAD_BEEF;
            endcase
        end
    end

    logic        prev_en = 1'b0;
    logic [66:0] prev_bus = '0;
    always_ff @(posedge clk) begin
        if (reset_n && alu_enable && prev_en &&
            ({alu_op_code, alu_operand1, alu_operand2} !== prev_bus)) begin
            stab_err <= stab_err + 1;
        end
        prev_en  <= alu_enable;
        prev_bus <= {alu_op_code, alu_operand1, alu_operand2};
    end

    typedef struct {
        logic [2:0]  op;
        logic [4:0]  dest;
        logic [31:0] data;
        int          lat;
        bit          wb;
        bit          ill;
        bit          dz;
    } exp_t;

    typedef struct {
        logic [31:0] ins;
        logic [31:0] rs;
        logic [31:0] rt;
        int          hold;
        logic [31:0] data;
        logic [4:0]  addr;
        string       name;
    } vec_t;

    vec_t tbl[14];

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
    endtask

    function automatic logic [31:0] rtype(input logic [4:0] rt, input logic [4:0] rd,
                                          input logic [4:0] sh, input logic [5:0] fn);
        return {6'h00, 5'd1, rt, rd, sh, fn};
    endfunction

    function automatic logic [31:0] itype(input logic [5:0] opc, input logic [4:0] rt,
                                          input logic [15:0] imm);
        return {opc, 5'd1, rt, imm};
    endfunction

    // What the instruction should do, straight from the MIPS semantics.
    function automatic exp_t ref_model(input logic [31:0] ins, input logic [31:0] rs,
                                       input logic [31:0] rt);
        exp_t        e;
        logic [5:0]  opc;
        logic [5:0]  fn;
        logic [31:0] imm;
        logic [4:0]  sh;
        opc = ins[31:26];
        fn  = ins[5:0];
        imm = {{16{ins[15]}}, ins[15:0]};
        sh  = ins[10:6];
        e   = '{op: 3'd0, dest: 5'd0, data: 32'd0, lat: 1, wb: 1'b0, ill: 1'b0, dz: 1'b0};
        if (opc == 6'h00) begin
            e.dest = ins[15:11];
            case (fn)
                6'h20: begin e.op = 3'd0; e.data = rs + rt; end
                6'h22: begin e.op = 3'd1; e.data = rs - rt; end
                6'h18: begin e.op = 3'd2; e.data = rs * rt; e.lat = LAT; end
                6'h1A: begin
                    e.op   = 3'd3;
                    e.lat  = LAT;
                    e.data = (rt == 0) ? 32'hFFFF_FFFF : rs / rt;
`ifdef ALU_DIVZERO_CHK_EN
                    if (rt == 0) begin e.lat = 0; e.dz = 1'b1; end
`endif
                end
                6'h00: begin e.op = 3'd4; e.data = rt << sh; end
                6'h02: begin e.op = 3'd5; e.data = rt >> sh; end
                default: e.ill = 1'b1;
            endcase
        end else if (opc == 6'h08) begin
            e.dest = ins[20:16];
            e.op   = 3'd0;
            e.data = rs + imm;
        end else begin
            e.ill = 1'b1;
        end
        if (e.ill) e.lat = 0;
        e.wb = !e.ill && (e.dest != 5'd0);
        return e;
    endfunction

    task automatic run_txn(input logic [31:0] ins, input logic [31:0] rs, input logic [31:0] rt,
                           input int hold, input exp_t e, input string name);
        int          en_cycles, wb_first, wb_cycles, ill_first, ill_cycles, dz_cycles;
        int          busy, stable_err, limit;
        logic [31:0] got_data;
        logic [4:0]  got_addr;
        logic [2:0]  got_op;
        en_cycles = 0; wb_first = 0; wb_cycles = 0; ill_first = 0; ill_cycles = 0;
        dz_cycles = 0; busy = 0; stable_err = 0;
        got_data = '0; got_addr = '0; got_op = '0;
        limit = e.lat + hold + 3;
        @(negedge clk);
        chk({name, "/ready_before"}, 64'(in_ready), 64'd1);
        instr = ins; rs_val = rs; rt_val = rt; in_valid = 1'b1;
        wb_ready = (hold == 0);
        @(posedge clk);
        for (int k = 1; k <= limit; k++) begin
            @(negedge clk);
            in_valid = 1'b0;
            if (alu_enable) begin
                if (en_cycles == 0) got_op = alu_op_code;
                en_cycles++;
            end
            if (illegal) begin
                if (ill_first == 0) ill_first = k;
                ill_cycles++;
            end
            if (divzero) dz_cycles++;
            if (!in_ready) busy++;
            if (wb_valid) begin
                wb_cycles++;
                if (wb_first == 0) begin
                    wb_first = k; got_data = wb_data; got_addr = wb_addr;
                end else if (wb_data !== got_data || wb_addr !== got_addr) begin
                    stable_err++;
                end
                if (k - wb_first >= hold) wb_ready = 1'b1;
            end
        end
        wb_ready = 1'b1;
        chk({name, "/enable_cycles"}, 64'(en_cycles), 64'(e.lat));
        if (e.lat > 0) chk({name, "/op_code"}, 64'(got_op), 64'(e.op));
        chk({name, "/wb_valid_cycle"}, 64'(wb_first), 64'(e.wb ? e.lat + 1 : 0));
        if (e.wb) begin
            chk({name, "/wb_data"}, 64'(got_data), 64'(e.data));
            chk({name, "/wb_addr"}, 64'(got_addr), 64'(e.dest));
            chk({name, "/wb_cycles"}, 64'(wb_cycles), 64'(hold + 1));
            chk({name, "/wb_stable"}, 64'(stable_err), 64'd0);
        end
        chk({name, "/illegal_pulse"}, {32'(ill_first), 32'(ill_cycles)},
            {32'(e.ill ? 1 : 0), 32'(e.ill ? 1 : 0)});
        chk({name, "/divzero_pulse"}, 64'(dz_cycles), 64'(e.dz ? 1 : 0));
        chk({name, "/busy_cycles"}, 64'(busy), 64'(e.lat + (e.wb ? hold + 1 : 0)));
    endtask

    task automatic check_idle_outputs(input string name);
        chk({name, "/in_ready"}, 64'(in_ready), 64'd1);
        chk({name, "/ctrl_zero"},
            64'({alu_enable, wb_valid, illegal, divzero, alu_op_code, wb_addr}), 64'd0);
        chk({name, "/operands_zero"}, {alu_operand1, alu_operand2}, 64'd0);
        chk({name, "/wb_data_zero"}, 64'(wb_data), 64'd0);
    endtask

    initial begin
        exp_t        e;
        logic [31:0] ins, rs, rt;
        int          hold, kind;
        bit          seen;

        reset_n = 1'b0; in_valid = 1'b0; wb_ready = 1'b1;
        instr = '0; rs_val = '0; rt_val = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_idle_outputs("reset");
        reset_n = 1'b1;

        tbl[0]  = '{rtype(5'd2, 5'd3, 5'd0, 6'h20), 32'd5, 32'd7, 0, 32'd12, 5'd3, "add"};
        tbl[1]  = '{itype(6'h08, 5'd4, 16'hFFFD), 32'd10, 32'd0, 0, 32'd7, 5'd4, "addi"};
        tbl[2]  = '{rtype(5'd2, 5'd5, 5'd0, 6'h18), 32'd6, 32'd7, 0, 32'd42, 5'd5, "mult"};
        tbl[3]  = '{rtype(5'd2, 5'd9, 5'd3, 6'h02), 32'd0, 32'h80, 5, 32'h10, 5'd9, "srl_bp"};
        tbl[4]  = '{{6'h23, 26'h0123456}, 32'd1, 32'd2, 0, 32'd0, 5'd0, "illegal_lw"};
        tbl[5]  = '{rtype(5'd2, 5'd0, 5'd0, 6'h20), 32'd5, 32'd7, 0, 32'd0, 5'd0, "add_rd0"};
        tbl[6]  = '{rtype(5'd2, 5'd7, 5'd0, 6'h22), 32'd3, 32'd5, 0, 32'hFFFF_FFFE, 5'd7, "sub"};
        tbl[7]  = '{rtype(5'd2, 5'd31, 5'd31, 6'h00), 32'd0, 32'd1, 1, 32'h8000_0000, 5'd31,
                    "sll31"};
        tbl[8]  = '{rtype(5'd2, 5'd2, 5'd0, 6'h1A), 32'd100, 32'd7, 0, 32'd14, 5'd2, "div"};
        tbl[9]  = '{rtype(5'd2, 5'd1, 5'd0, 6'h20), 32'hFFFF_FFFF, 32'd2, 0, 32'd1, 5'd1,
                    "add_wrap"};
        tbl[10] = '{rtype(5'd2, 5'd3, 5'd0, 6'h21), 32'd1, 32'd1, 0, 32'd0, 5'd0, "illegal_fn"};
        tbl[11] = '{rtype(5'd2, 5'd6, 5'd0, 6'h1A), 32'd55, 32'd0, 0, 32'hFFFF_FFFF, 5'd6,
                    "div_zero"};
        tbl[12] = '{rtype(5'd2, 5'd8, 5'd0, 6'h18), 32'h0001_0000, 32'h0001_0003, 0,
                    32'h0003_0000, 5'd8, "mult_low"};
        tbl[13] = '{itype(6'h08, 5'd0, 16'h0005), 32'd1, 32'd0, 0, 32'd0, 5'd0, "addi_rt0"};

        for (int i = 0; i < 14; i++) begin
            e = ref_model(tbl[i].ins, tbl[i].rs, tbl[i].rt);
            e.data = tbl[i].data;
            e.dest = tbl[i].addr;
            run_txn(tbl[i].ins, tbl[i].rs, tbl[i].rt, tbl[i].hold, e, tbl[i].name);
        end

        for (int i = 0; i < 60; i++) begin
            kind = $urandom_range(0, 8);
            rs   = $urandom;
            rt   = $urandom;
            hold = $urandom_range(0, 2);
            case (kind)
                0: ins = rtype(5'($urandom), 5'($urandom), 5'($urandom), 6'h20);
                1: ins = rtype(5'($urandom), 5'($urandom), 5'($urandom), 6'h22);
                2: ins = rtype(5'($urandom), 5'($urandom), 5'($urandom), 6'h18);
                3: begin
                    ins = rtype(5'($urandom), 5'($urandom), 5'($urandom), 6'h1A);
                    if ($urandom_range(0, 3) == 0) rt = 32'd0;
                    else rt = rt >> $urandom_range(0, 28);
                end
                4: ins = rtype(5'($urandom), 5'($urandom), 5'($urandom), 6'h00);
                5: ins = rtype(5'($urandom), 5'($urandom), 5'($urandom), 6'h02);
                6: ins = itype(6'h08, 5'($urandom), 16'($urandom));
                7: ins = {6'($urandom_range(1, 63)), 26'($urandom)};
                default: ins = rtype(5'($urandom), 5'($urandom), 5'($urandom), 6'($urandom));
            endcase
            e = ref_model(ins, rs, rt);
            run_txn(ins, rs, rt, hold, e, $sformatf("rand%0d", i));
        end

        // Reset while a divide is sitting in WAIT.
        @(negedge clk);
        instr = rtype(5'd2, 5'd3, 5'd0, 6'h1A); rs_val = 32'd100; rt_val = 32'd5;
        in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        chk("rst_wait/enable_before", 64'(alu_enable), 64'd1);
        reset_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check_idle_outputs("rst_wait");
        reset_n = 1'b1;

        // Reset while WB is stalled by the consumer.
        instr = rtype(5'd2, 5'd9, 5'd1, 6'h02); rs_val = 32'd0; rt_val = 32'h40;
        in_valid = 1'b1; wb_ready = 1'b0;
        @(posedge clk);
        seen = 1'b0;
        for (int k = 0; k < 10 && !seen; k++) begin
            @(negedge clk);
            in_valid = 1'b0;
            if (wb_valid) seen = 1'b1;
        end
        chk("rst_wb/reached_wb", 64'(seen), 64'd1);
        reset_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check_idle_outputs("rst_wb");
        reset_n = 1'b1;
        wb_ready = 1'b1;

        e = ref_model(tbl[0].ins, tbl[0].rs, tbl[0].rt);
        run_txn(tbl[0].ins, tbl[0].rs, tbl[0].rt, 0, e, "after_reset");

        chk("operand_stability", 64'(stab_err), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
